// File: rtl/jpeg_byte_unpacker_if.sv
// Word-in / byte-out stream bundle between the JPEG bitstream source and the byte sink.
// The unpacker uses the slave view; the producer/consumer side uses master.
interface jpeg_byte_unpacker_if;
    logic [31:0] s_data;
    logic        s_valid;
    logic        s_last;
    logic [4:0]  s_count;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_ready;
    logic        m_user;
    logic        m_last;

    modport master (
        output s_data, s_valid, s_last, s_count, m_ready,
        input  m_data, m_valid, m_user, m_last
    );

    modport slave (
        input  s_data, s_valid, s_last, s_count, m_ready,
        output m_data, m_valid, m_user, m_last
    );
endinterface

// File: rtl/jpeg_byte_unpacker.sv
// Buffers 32-bit JPEG bitstream words, frames them with SOI/EOI markers and
// serialises them MSB first onto a byte-wide valid/ready stream.
module jpeg_byte_unpacker #(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned FIFO_AW    = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    jpeg_byte_unpacker_if.slave     bus,
    output logic [23:0]             frame_bytes,
    output logic                    frame_done,
    output logic                    overflow
);
    localparam int unsigned WORD_W = 32;
    localparam int unsigned CNT_W  = 24;
    localparam int unsigned PTR_W  = FIFO_AW + 1;

    typedef struct packed {
        logic              last;
        logic [4:0]        count;
        logic [WORD_W-1:0] data;
    } fifo_entry_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SOI0,
        ST_SOI1,
        ST_DATA,
        ST_EOI0,
        ST_EOI1
    } state_t;

    // Word FIFO: extra pointer bit distinguishes full from empty
    fifo_entry_t        r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic               r_overflow;
    logic               w_empty;
    logic               w_full;
    logic               w_push;
    logic               w_pop;
    fifo_entry_t        w_head;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[FIFO_AW-1:0] == r_rd_ptr[FIFO_AW-1:0]) &&
                     (r_wr_ptr[FIFO_AW] != r_rd_ptr[FIFO_AW]);
    assign w_head  = r_mem[r_rd_ptr[FIFO_AW-1:0]];
    assign w_push  = bus.s_valid && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[FIFO_AW-1:0]] <= {bus.s_last, bus.s_count, bus.s_data};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (bus.s_valid && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Head word with JPEG 1-padding below the valid bit count of a final word
    logic [WORD_W-1:0]  w_pad_mask;
    logic [WORD_W-1:0]  w_head_word;
    logic [2:0]         w_head_nb;

    assign w_pad_mask  = w_head.last ? (32'hFFFF_FFFF >> w_head.count) : '0;
    assign w_head_word = w_head.data | w_pad_mask;
    assign w_head_nb   = w_head.last ? 3'((6'(w_head.count) + 6'd7) >> 3) : 3'd4;

    state_t             r_state;
    logic [7:0]         r_m_data;
    logic               r_m_valid;
    logic               r_m_user;
    logic               r_m_last;
    logic [23:0]        r_sr;
    logic [1:0]         r_rem;
    logic               r_sr_last;
    logic [CNT_W-1:0]   r_byte_cnt;
    logic [CNT_W-1:0]   r_frame_bytes;
    logic               r_frame_done;

    state_t             w_nx_state;
    logic [7:0]         w_nx_m_data;
    logic               w_nx_m_valid;
    logic               w_nx_m_user;
    logic               w_nx_m_last;
    logic [23:0]        w_nx_sr;
    logic [1:0]         w_nx_rem;
    logic               w_nx_sr_last;
    logic [CNT_W-1:0]   w_nx_byte_cnt;
    logic [CNT_W-1:0]   w_nx_frame_bytes;
    logic               w_nx_frame_done;
    logic               w_xfer;
    logic               w_load;
    logic [CNT_W-1:0]   w_cnt_inc;

    assign w_xfer    = r_m_valid && bus.m_ready;
    assign w_load    = !r_m_valid || bus.m_ready;
    assign w_cnt_inc = (r_byte_cnt == '1) ? r_byte_cnt : r_byte_cnt + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_m_data      <= '0;
            r_m_valid     <= 1'b0;
            r_m_user      <= 1'b0;
            r_m_last      <= 1'b0;
            r_sr          <= '0;
            r_rem         <= '0;
            r_sr_last     <= 1'b0;
            r_byte_cnt    <= '0;
            r_frame_bytes <= '0;
            r_frame_done  <= 1'b0;
        end else begin
            r_state       <= w_nx_state;
            r_m_data      <= w_nx_m_data;
            r_m_valid     <= w_nx_m_valid;
            r_m_user      <= w_nx_m_user;
            r_m_last      <= w_nx_m_last;
            r_sr          <= w_nx_sr;
            r_rem         <= w_nx_rem;
            r_sr_last     <= w_nx_sr_last;
            r_byte_cnt    <= w_nx_byte_cnt;
            r_frame_bytes <= w_nx_frame_bytes;
            r_frame_done  <= w_nx_frame_done;
        end
    end

    // Output register reloads whenever it is empty or its byte is being taken
    always_comb begin
        w_nx_state       = r_state;
        w_nx_m_data      = r_m_data;
        w_nx_m_valid     = r_m_valid;
        w_nx_m_user      = r_m_user;
        w_nx_m_last      = r_m_last;
        w_nx_sr          = r_sr;
        w_nx_rem         = r_rem;
        w_nx_sr_last     = r_sr_last;
        w_nx_byte_cnt    = w_xfer ? w_cnt_inc : r_byte_cnt;
        w_nx_frame_bytes = r_frame_bytes;
        w_nx_frame_done  = 1'b0;
        w_pop            = 1'b0;

        if (w_load) begin
            w_nx_m_valid = 1'b0;
            w_nx_m_user  = 1'b0;
            w_nx_m_last  = 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty) begin
                        w_nx_m_data   = 8'hFF;
                        w_nx_m_valid  = 1'b1;
                        w_nx_m_user   = 1'b1;
                        w_nx_rem      = '0;
                        w_nx_sr_last  = 1'b0;
                        w_nx_byte_cnt = '0;
                        w_nx_state    = ST_SOI0;
                    end
                end
                ST_SOI0: begin
                    w_nx_m_data  = 8'hD8;
                    w_nx_m_valid = 1'b1;
                    w_nx_state   = ST_SOI1;
                end
                ST_SOI1, ST_DATA: begin
                    w_nx_state = ST_DATA;
                    if (r_rem != '0) begin
                        w_nx_m_data  = r_sr[23:16];
                        w_nx_m_valid = 1'b1;
                        w_nx_sr      = {r_sr[15:0], 8'h00};
                        w_nx_rem     = r_rem - 2'd1;
                    end else if (r_sr_last) begin
                        w_nx_m_data  = 8'hFF;
                        w_nx_m_valid = 1'b1;
                        w_nx_sr_last = 1'b0;
                        w_nx_state   = ST_EOI0;
                    end else if (!w_empty) begin
                        w_pop = 1'b1;
                        if (w_head_nb == 3'd0) begin
                            w_nx_m_data  = 8'hFF;
                            w_nx_m_valid = 1'b1;
                            w_nx_sr_last = 1'b0;
                            w_nx_state   = ST_EOI0;
                        end else begin
                            w_nx_m_data  = w_head_word[31:24];
                            w_nx_m_valid = 1'b1;
                            w_nx_sr      = w_head_word[23:0];
                            w_nx_rem     = 2'(w_head_nb - 3'd1);
                            w_nx_sr_last = w_head.last;
                        end
                    end
                end
                ST_EOI0: begin
                    w_nx_m_data  = 8'hD9;
                    w_nx_m_valid = 1'b1;
                    w_nx_m_last  = 1'b1;
                    w_nx_state   = ST_EOI1;
                end
                ST_EOI1: begin
                    w_nx_frame_done  = 1'b1;
                    w_nx_frame_bytes = w_nx_byte_cnt;
                    w_nx_state       = ST_IDLE;
                end
                default: begin
                    w_nx_state = ST_IDLE;
                end
            endcase
        end
    end

    assign bus.m_data  = r_m_data;
    assign bus.m_valid = r_m_valid;
    assign bus.m_user  = r_m_user;
    assign bus.m_last  = r_m_last;
    assign frame_bytes = r_frame_bytes;
    assign frame_done  = r_frame_done;
    assign overflow    = r_overflow;
endmodule

// File: tb/tb_jpeg_byte_unpacker.sv
// Randomised bench for jpeg_byte_unpacker: expected byte streams come from a
// per-frame reference model built from word lists.
module tb_jpeg_byte_unpacker;
    localparam int unsigned DEPTH = 16;

    typedef struct {
        logic [31:0] data;
        logic        last;
        logic [4:0]  cnt;
    } word_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] frame_bytes;
    logic        frame_done;
    logic        overflow;

    jpeg_byte_unpacker_if bus();

    jpeg_byte_unpacker #(.FIFO_DEPTH(DEPTH), .FIFO_AW(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus.slave),
        .frame_bytes (frame_bytes),
        .frame_done  (frame_done),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad   = 0;
    int         rdy_mode = 1;   // 0: hold low, 1: hold high, 2: random
    logic [9:0] rx[$];
    logic [9:0] exp_q[$];
    int         done_q[$];
    int         exp_done[$];
    logic [9:0] prev_byte;
    logic       prev_stall = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic word_t mk(input logic [31:0] d, input logic l, input logic [4:0] c);
        word_t w;
        w.data = d;
        w.last = l;
        w.cnt  = c;
        return w;
    endfunction

    // Reference: markers around the word bytes, final word trimmed and 1-padded
    function automatic void model_frame(input word_t w[$]);
        int n = 4;
        exp_q.push_back({1'b1, 1'b0, 8'hFF});
        exp_q.push_back({2'b00, 8'hD8});
        foreach (w[i]) begin
            int nb = w[i].last ? (int'(w[i].cnt) + 7) / 8 : 4;
            for (int k = 0; k < nb; k++) begin
                logic [7:0] b   = w[i].data[31 - 8*k -: 8];
                int         rem = int'(w[i].cnt) - 8*k;
                if (w[i].last && rem < 8) b = b | 8'((1 << (8 - rem)) - 1);
                exp_q.push_back({2'b00, b});
                n++;
            end
        end
        exp_q.push_back({2'b00, 8'hFF});
        exp_q.push_back({1'b0, 1'b1, 8'hD9});
        exp_done.push_back(n);
    endfunction

    task automatic send_words(input word_t w[$]);
        foreach (w[i]) begin
            bus.s_data  = w[i].data;
            bus.s_last  = w[i].last;
            bus.s_count = w[i].cnt;
            bus.s_valid = 1'b1;
            @(posedge clk); #1;
        end
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    task automatic wait_rx(input string tag, input int n);
        int cyc = 0;
        while (rx.size() < n && cyc < 5000) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (rx.size() < n) check_eq({tag, "_timeout"}, 32'(rx.size()), 32'(n));
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic compare_stream(input string tag);
        check_eq({tag, "_len"}, 32'(rx.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            logic [31:0] g = (i < rx.size()) ? 32'(rx[i]) : 32'hFFFF_FFFF;
            check_eq({tag, "_byte"}, g, 32'(exp_q[i]));
        end
        check_eq({tag, "_ndone"}, 32'(done_q.size()), 32'(exp_done.size()));
        for (int i = 0; i < exp_done.size(); i++) begin
            logic [31:0] g = (i < done_q.size()) ? 32'(done_q[i]) : 32'hFFFF_FFFF;
            check_eq({tag, "_fbytes"}, g, 32'(exp_done[i]));
        end
        rx.delete();
        exp_q.delete();
        done_q.delete();
        exp_done.delete();
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_valid"}, 32'(bus.m_valid), 32'd0);
        check_eq({tag, "_user"},  32'(bus.m_user), 32'd0);
        check_eq({tag, "_last"},  32'(bus.m_last), 32'd0);
        check_eq({tag, "_data"},  32'(bus.m_data), 32'd0);
        check_eq({tag, "_fbytes"}, 32'(frame_bytes), 32'd0);
        check_eq({tag, "_fdone"}, 32'(frame_done), 32'd0);
        check_eq({tag, "_ovf"},   32'(overflow), 32'd0);
    endtask

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       bus.m_ready = 1'b0;
            1:       bus.m_ready = 1'b1;
            default: bus.m_ready = 1'($urandom);
        endcase
    end

    // Byte/frame monitor plus hold-stable check during sink stalls
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                check_eq("hold", {21'd0, bus.m_valid, bus.m_user, bus.m_last, bus.m_data}, {21'd0, 1'b1, prev_byte});
            if (bus.m_valid && bus.m_ready) rx.push_back({bus.m_user, bus.m_last, bus.m_data});
            if (frame_done) done_q.push_back(int'(frame_bytes));
            prev_stall = bus.m_valid && !bus.m_ready;
            prev_byte  = {bus.m_user, bus.m_last, bus.m_data};
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        word_t w[$];
        word_t w2[$];
        rst = 1'b1;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.s_last  = 1'b0;
        bus.s_count = '0;
        bus.m_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("reset");
        @(posedge clk); #1;

        // Known frame with first-byte latency check
        w = {mk(32'h12345678, 1'b0, 5'd0), mk(32'h9ABC0000, 1'b1, 5'd16)};
        model_frame(w);
        bus.s_data = w[0].data; bus.s_last = 1'b0; bus.s_count = 5'd0; bus.s_valid = 1'b1;
        @(posedge clk); #1;
        bus.s_data = w[1].data; bus.s_last = 1'b1; bus.s_count = w[1].cnt;
        @(negedge clk);
        check_eq("lat_n1_valid", 32'(bus.m_valid), 32'd0);
        @(posedge clk); #1;
        bus.s_valid = 1'b0; bus.s_last = 1'b0;
        @(negedge clk);
        check_eq("lat_n2_soi", {22'd0, bus.m_valid, bus.m_user, bus.m_data}, {22'd0, 1'b1, 1'b1, 8'hFF});
        @(posedge clk); #1;
        wait_rx("t1", exp_q.size());
        compare_stream("t1");

        // Partial final byte padding, then zero-count final word
        w = {mk(32'hDEADBEEF, 1'b0, 5'd0), mk(32'hA5800000, 1'b1, 5'd9)};
        model_frame(w);
        send_words(w);
        wait_rx("t2a", exp_q.size());
        compare_stream("t2a");
        w = {mk(32'h11223344, 1'b0, 5'd0), mk(32'hFFFFFFFF, 1'b1, 5'd0)};
        model_frame(w);
        send_words(w);
        wait_rx("t2b", exp_q.size());
        compare_stream("t2b");

        // Random 8-word frames under random sink backpressure
        rdy_mode = 2;
        for (int f = 0; f < 4; f++) begin
            w.delete();
            for (int i = 0; i < 7; i++) w.push_back(mk($urandom, 1'b0, 5'd0));
            w.push_back(mk($urandom, 1'b1, 5'($urandom_range(0, 31))));
            model_frame(w);
            send_words(w);
            wait_rx("t3", exp_q.size());
            compare_stream("t3");
        end

        // Two back-to-back frames
        w  = {mk($urandom, 1'b0, 5'd0), mk($urandom, 1'b0, 5'd0), mk($urandom, 1'b1, 5'd31)};
        w2 = {mk($urandom, 1'b0, 5'd0), mk($urandom, 1'b1, 5'd5)};
        model_frame(w);
        model_frame(w2);
        send_words({w, w2});
        wait_rx("t6", exp_q.size());
        compare_stream("t6");
        check_eq("no_ovf", 32'(overflow), 32'd0);

        // Overflow: 20 words into a stalled 16-deep FIFO
        rdy_mode = 0;
        repeat (3) @(posedge clk);
        #1;
        w.delete();
        for (int i = 0; i < 20; i++) w.push_back(mk($urandom, 1'b0, 5'd0));
        send_words(w);
        repeat (2) @(posedge clk);
        #1;
        check_eq("ovf_set", 32'(overflow), 32'd1);
        check_eq("ovf_rx_none", 32'(rx.size()), 32'd0);
        w2 = w[0:DEPTH-1];
        w2.push_back(mk(32'h0, 1'b1, 5'd0));
        model_frame(w2);
        rdy_mode = 1;
        wait_rx("t4a", 2 + 4 * DEPTH);
        send_words({mk(32'h0, 1'b1, 5'd0)});
        wait_rx("t4b", exp_q.size());
        compare_stream("t4");
        check_eq("ovf_sticky", 32'(overflow), 32'd1);

        // Reset mid-frame flushes everything
        w.delete();
        for (int i = 0; i < 4; i++) w.push_back(mk($urandom, 1'b0, 5'd0));
        send_words(w);
        begin
            int cyc = 0;
            while (rx.size() < 5 && cyc < 200) begin
                @(posedge clk); #1;
                cyc++;
            end
            check_eq("t5_reach5", 32'(rx.size() >= 5), 32'd1);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("midrst");
        @(posedge clk); #1;
        rx.delete();
        done_q.delete();
        w = {mk(32'hCAFEF00D, 1'b0, 5'd0), mk(32'h80000000, 1'b1, 5'd1)};
        model_frame(w);
        send_words(w);
        wait_rx("t5", exp_q.size());
        compare_stream("t5");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
